timing_counter: RTL and testbench

Parametrised pixel-clock counter for the VGA timing path: counts 0..STOP with enable, wrap or one-shot mode, synchronous clear and load, and a same-cycle terminal-count output for cascading (horizontal counter's `tc` drives vertical counter's `en`). It also decodes registered `active` and `sync` windows aligned to `val`, so a horizontal/vertical pair plus an AND gate forms a complete VGA timing generator.

---
 rtl/timing_counter.sv | 101 ++++++++++
 tb/tb_timing_counter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/timing_counter.sv
// Pixel-clock counter for VGA timing: counts 0..STOP with wrap or one-shot,
// cascade terminal count, and registered active/sync windows aligned to val.
module timing_counter #(
   parameter int   WIDTH      = 12,
   parameter int   STOP       = 799,
   parameter int   ACTIVE_END = 639,
   parameter int   SYNC_START = 656,
   parameter int   SYNC_END   = 751,
   parameter logic SYNC_POL   = 1'b0,
   parameter logic ONE_SHOT   = 1'b0
) (
   input  logic             pix_clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] val,
   output logic             tc,
   output logic             active,
   output logic             sync,
   output logic             done
);

   localparam logic [WIDTH-1:0] STOP_V       = WIDTH'(STOP);
   localparam logic [WIDTH-1:0] ACTIVE_END_V = WIDTH'(ACTIVE_END);
   localparam logic [WIDTH-1:0] SYNC_START_V = WIDTH'(SYNC_START);
   localparam logic [WIDTH-1:0] SYNC_END_V   = WIDTH'(SYNC_END);

   // Reject inconsistent parameter sets before any hardware is built.
   generate
      if (WIDTH < 1 || WIDTH > 62) begin : g_bad_width
         $error("timing_counter: WIDTH out of range");
      end
      if (STOP < 1 || longint'(STOP) >= (64'sd1 <<< WIDTH)) begin : g_bad_stop
         $error("timing_counter: STOP must satisfy 1 <= STOP < 2**WIDTH");
      end
      if (ACTIVE_END < 0 || ACTIVE_END > STOP) begin : g_bad_active
         $error("timing_counter: ACTIVE_END must be <= STOP");
      end
      if (SYNC_START < 0 || SYNC_START > SYNC_END || SYNC_END > STOP) begin : g_bad_sync
         $error("timing_counter: need SYNC_START <= SYNC_END <= STOP");
      end
   endgenerate

   logic [WIDTH-1:0] val_reg, val_next;
   logic             done_reg, done_next;
   logic             active_reg;
   logic             sync_reg;

   function automatic logic active_of(input logic [WIDTH-1:0] v);
      return (v <= ACTIVE_END_V);
   endfunction

   function automatic logic sync_of(input logic [WIDTH-1:0] v);
      return ((v >= SYNC_START_V) && (v <= SYNC_END_V)) ? SYNC_POL : ~SYNC_POL;
   endfunction

   // Priority: clr > load > en > hold; rst is handled in the register process.
   always_comb begin
      val_next  = val_reg;
      done_next = done_reg;
      if (clr) begin
         val_next  = '0;
         done_next = 1'b0;
      end else if (load) begin
         val_next  = (load_val > STOP_V) ? STOP_V : load_val;
         done_next = 1'b0;
      end else if (en && !done_reg) begin
         if (val_reg != STOP_V) begin
            val_next = val_reg + 1'b1;
         end else if (ONE_SHOT) begin
            done_next = 1'b1;
         end else begin
            val_next = '0;
         end
      end
   end

   // Windows are decoded from the next value so they line up with val.
   always_ff @(posedge pix_clk) begin
      if (rst) begin
         val_reg    <= '0;
         done_reg   <= 1'b0;
         active_reg <= 1'b1;
         sync_reg   <= sync_of({WIDTH{1'b0}});
      end else begin
         val_reg    <= val_next;
         done_reg   <= done_next;
         active_reg <= active_of(val_next);
         sync_reg   <= sync_of(val_next);
      end
   end

   assign val    = val_reg;
   assign done   = done_reg;
   assign active = active_reg;
   assign sync   = sync_reg;
   assign tc     = en & (val_reg == STOP_V) & ~done_reg;

endmodule

// File: tb/tb_timing_counter.sv
// Bench for timing_counter: a wrapping counter, a one-shot counter on the same
// stimulus, and a cascaded STOP=3 counter driven by the wrapping counter's tc.
module tb_timing_counter;

   logic       pix_clk = 1'b0;
   logic       rst = 1'b1, en = 1'b0, clr = 1'b0, load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] val_a, val_b, val_c;
   logic       tc_a, tc_b, tc_c;
   logic       active_a, active_b, active_c;
   logic       sync_a, sync_b, sync_c;
   logic       done_a, done_b, done_c;

   int tests = 0;
   int fails = 0;

   // Reference state: plain integer counts.
   int  m_a = 0, d_a = 0, m_b = 0, d_b = 0, m_c = 0;
   bit  m_valid = 0;

   always #5 pix_clk = ~pix_clk;

   timing_counter #(.WIDTH(4), .STOP(9), .ACTIVE_END(5), .SYNC_START(7), .SYNC_END(8),
                    .SYNC_POL(1'b0), .ONE_SHOT(1'b0)) u_wrap (
      .pix_clk(pix_clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
      .val(val_a), .tc(tc_a), .active(active_a), .sync(sync_a), .done(done_a));

   timing_counter #(.WIDTH(4), .STOP(9), .ACTIVE_END(5), .SYNC_START(7), .SYNC_END(8),
                    .SYNC_POL(1'b0), .ONE_SHOT(1'b1)) u_shot (
      .pix_clk(pix_clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
      .val(val_b), .tc(tc_b), .active(active_b), .sync(sync_b), .done(done_b));

   timing_counter #(.WIDTH(4), .STOP(3), .ACTIVE_END(1), .SYNC_START(2), .SYNC_END(3),
                    .SYNC_POL(1'b0), .ONE_SHOT(1'b0)) u_casc (
      .pix_clk(pix_clk), .rst(rst), .en(tc_a), .clr(1'b0), .load(1'b0), .load_val(4'd0),
      .val(val_c), .tc(tc_c), .active(active_c), .sync(sync_c), .done(done_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Returns next count plus 1000*done, from the counter's behavioural rules.
   function automatic int model_next(input int v, input int d, input bit r, input bit e,
                                     input bit c, input bit l, input int lv,
                                     input int stop, input bit one_shot);
      if (r || c) return 0;
      if (l) return (lv > stop) ? stop : lv;
      if (!e || d != 0) return v + 1000 * d;
      if (v < stop) return v + 1;
      return one_shot ? (stop + 1000) : 0;
   endfunction

   task automatic step(input bit r, input bit e, input bit c, input bit l, input int lv);
      int  na, nb;
      bit  tc_a_exp;
      rst = r; en = e; clr = c; load = l; load_val = 4'(lv);
      #1;
      tc_a_exp = e && (m_a == 9) && (d_a == 0);
      if (m_valid) begin
         chk("tc_a", tc_a, tc_a_exp);
         chk("tc_b", tc_b, e && (m_b == 9) && (d_b == 0));
         chk("tc_c", tc_c, tc_a_exp && (m_c == 3));
      end
      @(posedge pix_clk);
      na = model_next(m_a, d_a, r, e, c, l, lv, 9, 1'b0);
      nb = model_next(m_b, d_b, r, e, c, l, lv, 9, 1'b1);
      m_a = na % 1000; d_a = na / 1000;
      m_b = nb % 1000; d_b = nb / 1000;
      if (r) m_c = 0;
      else if (m_valid && tc_a_exp) m_c = (m_c + 1) % 4;
      m_valid = 1;
      #1;
      chk("val_a", val_a, m_a);
      chk("done_a", done_a, 0);
      chk("active_a", active_a, m_a <= 5);
      chk("sync_a", sync_a, !(m_a >= 7 && m_a <= 8));
      chk("val_b", val_b, m_b);
      chk("done_b", done_b, d_b);
      chk("active_b", active_b, m_b <= 5);
      chk("sync_b", sync_b, !(m_b >= 7 && m_b <= 8));
      chk("val_c", val_c, m_c);
      chk("active_c", active_c, m_c <= 1);
      chk("sync_c", sync_c, m_c < 2);
      $display("[TB] t=%0t rst=%b en=%b clr=%b load=%b lv=%0d | a=%0d tc=%b | b=%0d done=%b | c=%0d",
               $time, r, e, c, l, lv, val_a, tc_a, val_b, done_b, val_c);
   endtask

   initial begin
      // Reset, including a cycle with en high while rst is held.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("reset_sync", sync_a, 1);
      chk("reset_active", active_a, 1);

      // Free run from reset: wraps twice in the first 25 cycles, one-shot
      // stops at 9 and holds, cascade wraps after 40 cycles.
      for (int k = 0; k < 45; k++) step(0, 1, 0, 0, 0);
      chk("oneshot_hold_val", val_b, 9);
      chk("oneshot_done", done_b, 1);
      chk("cascade_after_45", val_c, 0);

      // clr restarts both counters.
      step(0, 1, 1, 0, 0);
      for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 0);

      // en toggling from val=8.
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // load wins over en; oversize load clamps to STOP.
      step(0, 1, 0, 1, 3);
      step(0, 0, 0, 1, 15);
      step(0, 1, 0, 1, 3);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
      // rst at val=6 overrides clr, load and en.
      step(1, 1, 1, 1, 12);

      // Randomised phase.
      for (int k = 0; k < 300; k++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
